bpsk_tx_sequencer: RTL and testbench
====================================

// Module: bpsk_tx_sequencer
// PURPOSE
//  Frame sequencer for the bpsk modulator. Accepts data bytes over a valid/ready handshake and
//  frames them as preamble, then data bits MSB-first, then guard symbols.
//  Drives the modulator's significant_bit, holding each bit for SPS carrier samples.
//  Sits between the byte source and bpsk; runs on the DDS sample clock, one sample per cycle.
// PARAMETERS
//  DATA_W        8      byte width; also preamble length in bits
//  SPS           16     carrier samples per symbol (>=2)
//  PREAMBLE      8'hAA  preamble pattern, sent MSB first
//  GUARD_SYMS    2      trailing zero-bit symbols after the last data bit (>=1)
// PORTS
//  sychronizer    in   1        sample clock, rising edge
//  reset_n        in   1        asynchronous active-low reset
//  byte_in        in   DATA_W   data byte
//  byte_last      in   1        qualifies byte_in as the final byte of the frame
//  byte_valid     in   1        source has a byte
//  byte_ready     out  1        sequencer accepts a byte this cycle
//  significant_bit out 1        symbol bit to bpsk (1 = 0 deg, 0 = 180 deg)
//  tx_enable      out  1        modulator output gate; high from first preamble to last guard sample
//  symbol_strobe  out  1        1-cycle pulse on the first sample of every transmitted symbol
//  frame_done     out  1        1-cycle pulse when a frame (normal or aborted) completes
//  underrun       out  1        1-cycle pulse when a data byte is needed but hold register is empty
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; every output 0; hold register empty; counters 0.
//    Reset mid-frame aborts immediately, with no frame_done.
//  - All outputs registered. byte_ready = !hold_full (also during GUARD/IDLE).
//  - Handshake: byte_valid&&byte_ready at edge k loads {byte_last,byte_in} into hold; hold_full=1 after k.
//  - Sample counter 0..SPS-1; bit counter 0..DATA_W-1 (preamble/data) or 0..GUARD_SYMS-1 (guard).
//    End of symbol = sample counter at SPS-1; it wraps to 0.
//  - FSM states: IDLE, PREAMBLE, DATA, GUARD.
//   IDLE: significant_bit=0, tx_enable=0. If hold_full, go to PREAMBLE at the next edge.
//     tx_enable=1, significant_bit=PREAMBLE[DATA_W-1], symbol_strobe=1 in that same first cycle.
//   PREAMBLE: each bit lasts SPS cycles. After the last sample of bit DATA_W-1:
//     load the shifter from hold, clear hold_full, go to DATA, output data bit MSB.
//   DATA: shift MSB-first. At the end of the last bit of the byte:
//     - byte was flagged last: go to GUARD.
//     - else if hold_full: load the next byte with no gap and clear hold_full.
//     - else: pulse underrun and go to GUARD. The partial frame is aborted.
//   GUARD: significant_bit=0, tx_enable=1 for GUARD_SYMS*SPS cycles.
//     Then go to IDLE, tx_enable=0, frame_done=1 for that single cycle.
//  - symbol_strobe=1 whenever the sample counter is 0 and state != IDLE.
//  - Simultaneous events:
//     - Hold load and hold drain in the same cycle cannot occur, since ready is low while full.
//       The drain at edge j makes byte_ready=1 from j+1.
//     - A byte accepted in GUARD or on the frame_done cycle starts a new frame from IDLE next cycle.
//       The minimum inter-frame gap is one IDLE cycle.
//  - Frame length: (DATA_W*(1+N)+GUARD_SYMS)*SPS cycles of tx_enable for N data bytes.
// STRUCTURE
//  - Shared package bpsk_pkg: state enum (IDLE/PREAMBLE/DATA/GUARD), default PREAMBLE constant,
//    SPS/DATA_W defaults shared with bpsk and its DDS.
//  - One sub-module: bpsk_symbol_timer. It holds the sample counter and bit counter and emits
//    sym_start/sym_end/bits_done; it is reloaded by the FSM on state entry.
//  - The FSM, hold register, and shifter live in the top module.
// TESTING (bench: SPS=4, GUARD_SYMS=2, PREAMBLE=8'hAA, 10 ns clock)
//  - Single byte 0xA5, last=1:
//    - tx_enable for exactly (8+8+2)*4=72 cycles.
//    - significant_bit = 1,0,1,0,1,0,1,0 then 1,0,1,0,0,1,0,1 then 0,0, each held 4 cycles.
//    - frame_done on cycle 73; 18 symbol_strobes.
//  - Back-to-back 0x3C,0xFF(last):
//    - the second byte is accepted during the first byte's DATA.
//    - no gap between the bytes; tx_enable lasts 104 cycles; byte_ready deasserts while hold is full.
//  - Underrun: 0x81 with last=0 and no further byte:
//    - underrun pulses once at the end of the 0x81 data bits; 2 guard symbols follow.
//    - frame_done occurs after 72 cycles total.
//  - Reset mid-DATA (reset_n low at sample 2 of the bit-3 symbol):
//    - all outputs 0 asynchronously; no frame_done.
//    - a fresh byte after release starts with the preamble.
//  - Byte with last=1 offered during GUARD:
//    - accepted immediately; frame_done cycle is IDLE.
//    - the next preamble starts the following cycle.
//  - Held byte_valid with byte_ready=0: byte_in must not be sampled.
//    Changing byte_in while ready=0 does not corrupt the output bits.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared definitions for the bpsk transmit path.
// The sequencer, the modulator and its DDS all take their defaults from here.
// That keeps the symbol rate and byte width consistent across the chain.
package bpsk_pkg;

  // Default byte width. The preamble is one byte long, so this is also the preamble length.
  localparam int DEFAULT_DATA_W = 8;

  // Default number of DDS carrier samples per transmitted symbol.
  localparam int DEFAULT_SPS = 16;

  // Default number of trailing zero-bit symbols that close a frame.
  localparam int DEFAULT_GUARD_SYMS = 2;

  // Default alternating preamble. It gives the receiver clean phase reversals to lock onto.
  localparam logic [7:0] DEFAULT_PREAMBLE = 8'hAA;

  // Frame sequencer states, in the order a frame passes through them.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_GUARD    = 2'd3
  } seq_state_t;

  // Width of a counter that runs 0..n-1.
  // It never returns less than 1, so the counter always has a real vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Larger of two integers. Used to size a counter shared by several phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bpsk_symbol_timer.sv
// Symbol timing for the bpsk sequencer.
// A sample counter runs 0..SPS-1 inside each symbol.
// A bit counter runs 0..bit_limit across the symbols of the current phase.
// The FSM reloads both counters whenever it enters a new state.
module bpsk_symbol_timer
  import bpsk_pkg::*;
#(
  parameter int SPS   = DEFAULT_SPS,
  parameter int BIT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             run,
  input  logic [BIT_W-1:0] bit_limit,
  output logic             sym_start,
  output logic             sym_end,
  output logic             bits_done
);

  localparam int SAMPLE_W = cnt_width(SPS);
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(SPS - 1);

  logic [SAMPLE_W-1:0] sample_cnt;
  logic [BIT_W-1:0]    bit_cnt;

  // The current cycle is the last sample of a symbol only while a phase is running.
  assign sym_end   = run && (sample_cnt == LAST_SAMPLE);

  // The last sample of the last symbol in the current phase.
  assign bits_done = sym_end && (bit_cnt == bit_limit);

  // The coming cycle carries the first sample of a symbol.
  // That happens either because the FSM is entering a new state or because the running symbol wraps.
  assign sym_start = reload || sym_end;

  // Advance the sample counter each cycle and step the bit counter at every symbol boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else if (reload) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else if (run) begin
      if (sym_end) begin
        sample_cnt <= '0;
        bit_cnt    <= bits_done ? '0 : bit_cnt + BIT_W'(1);
      end else begin
        sample_cnt <= sample_cnt + SAMPLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/bpsk_tx_sequencer.sv
// Frame sequencer in front of the bpsk modulator.
// Bytes arrive over a valid/ready handshake and are parked in a one-deep hold register.
// Each frame is sent as the preamble, then the data bits MSB-first, then zero-bit guard symbols.
// Every symbol bit is held on significant_bit for SPS sample-clock cycles.
// All outputs are registered, so they change only on the sample clock or on reset.
module bpsk_tx_sequencer
  import bpsk_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter int                SPS        = DEFAULT_SPS,
  parameter logic [DATA_W-1:0] PREAMBLE   = DEFAULT_PREAMBLE,
  parameter int                GUARD_SYMS = DEFAULT_GUARD_SYMS
) (
  input  logic              sychronizer,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_last,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              significant_bit,
  output logic              tx_enable,
  output logic              symbol_strobe,
  output logic              frame_done,
  output logic              underrun
);

  // One bit counter covers both the byte-long phases and the guard phase.
  localparam int BIT_W = cnt_width(max_int(DATA_W, GUARD_SYMS));
  localparam logic [BIT_W-1:0] BYTE_LIMIT  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] GUARD_LIMIT = BIT_W'(GUARD_SYMS - 1);

  seq_state_t        state;

  // One-deep hold register between the byte source and the shifter.
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_full;
  logic              hold_full_nxt;
  logic              load;
  logic              drain;

  // Shifter for the symbol on air. Its MSB is always the bit currently being sent.
  logic [DATA_W-1:0] shifter;
  logic              cur_last;

  // Handshake with the symbol timer.
  logic              reload;
  logic              run;
  logic [BIT_W-1:0]  bit_limit;
  logic              sym_start;
  logic              sym_end;
  logic              bits_done;

  assign run       = (state != S_IDLE);
  assign bit_limit = (state == S_GUARD) ? GUARD_LIMIT : BYTE_LIMIT;

  bpsk_symbol_timer #(
    .SPS   (SPS),
    .BIT_W (BIT_W)
  ) u_timer (
    .clk       (sychronizer),
    .rst_n     (reset_n),
    .reload    (reload),
    .run       (run),
    .bit_limit (bit_limit),
    .sym_start (sym_start),
    .sym_end   (sym_end),
    .bits_done (bits_done)
  );

  // Decide when the hold register drains into the shifter and when the timer restarts for a new state.
  always_comb begin
    load   = byte_valid && byte_ready;
    drain  = 1'b0;
    reload = 1'b0;
    case (state)
      S_IDLE: begin
        reload = hold_full;
      end
      S_PREAMBLE: begin
        drain  = bits_done;
        reload = bits_done;
      end
      S_DATA: begin
        drain  = bits_done && !cur_last && hold_full;
        reload = bits_done && (cur_last || !hold_full);
      end
      S_GUARD: begin
        reload = bits_done;
      end
    endcase
    hold_full_nxt = load ? 1'b1 : (drain ? 1'b0 : hold_full);
  end

  // Capture an accepted byte. byte_ready mirrors the emptiness the hold register will have next cycle.
  always_ff @(posedge sychronizer or negedge reset_n) begin
    if (!reset_n) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      if (load) begin
        hold_data <= byte_in;
        hold_last <= byte_last;
      end
      hold_full  <= hold_full_nxt;
      byte_ready <= !hold_full_nxt;
    end
  end

  // Frame FSM. It walks IDLE, PREAMBLE, DATA and GUARD and registers every modulator-facing output.
  always_ff @(posedge sychronizer or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      shifter         <= '0;
      cur_last        <= 1'b0;
      significant_bit <= 1'b0;
      tx_enable       <= 1'b0;
      symbol_strobe   <= 1'b0;
      frame_done      <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
      symbol_strobe <= sym_start && !(state == S_GUARD && bits_done);

      case (state)
        S_IDLE: begin
          significant_bit <= 1'b0;
          tx_enable       <= 1'b0;
          if (hold_full) begin
            state           <= S_PREAMBLE;
            shifter         <= PREAMBLE;
            significant_bit <= PREAMBLE[DATA_W-1];
            tx_enable       <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          if (bits_done) begin
            state           <= S_DATA;
            shifter         <= hold_data;
            cur_last        <= hold_last;
            significant_bit <= hold_data[DATA_W-1];
          end else if (sym_end) begin
            shifter         <= {shifter[DATA_W-2:0], 1'b0};
            significant_bit <= shifter[DATA_W-2];
          end
        end

        S_DATA: begin
          if (bits_done) begin
            if (cur_last) begin
              state           <= S_GUARD;
              significant_bit <= 1'b0;
            end else if (hold_full) begin
              shifter         <= hold_data;
              cur_last        <= hold_last;
              significant_bit <= hold_data[DATA_W-1];
            end else begin
              state           <= S_GUARD;
              significant_bit <= 1'b0;
              underrun        <= 1'b1;
            end
          end else if (sym_end) begin
            shifter         <= {shifter[DATA_W-2:0], 1'b0};
            significant_bit <= shifter[DATA_W-2];
          end
        end

        S_GUARD: begin
          significant_bit <= 1'b0;
          if (bits_done) begin
            state      <= S_IDLE;
            tx_enable  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Directed bench for bpsk_tx_sequencer with SPS=4, GUARD_SYMS=2, PREAMBLE=8'hAA and a 10 ns clock.
// A monitor records every transmitted sample and event on the falling edge.
// The main sequence compares those records with hand-computed frame shapes.
module tb_bpsk_tx_sequencer;

  localparam int SPS        = 4;
  localparam int DATA_W     = 8;
  localparam int GUARD_SYMS = 2;

  logic              sychronizer;
  logic              reset_n;
  logic [DATA_W-1:0] byte_in;
  logic              byte_last;
  logic              byte_valid;
  logic              byte_ready;
  logic              significant_bit;
  logic              tx_enable;
  logic              symbol_strobe;
  logic              frame_done;
  logic              underrun;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc          = 0;
  int tx_cnt       = 0;
  int strobe_cnt   = 0;
  int done_cnt     = 0;
  int underrun_cnt = 0;
  int rise_cyc     = 0;
  int done_cyc     = 0;
  int underrun_cyc = 0;
  logic tx_prev    = 1'b0;
  logic bits_q[$];

  bpsk_tx_sequencer #(
    .DATA_W     (DATA_W),
    .SPS        (SPS),
    .PREAMBLE   (8'hAA),
    .GUARD_SYMS (GUARD_SYMS)
  ) dut (
    .sychronizer     (sychronizer),
    .reset_n         (reset_n),
    .byte_in         (byte_in),
    .byte_last       (byte_last),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .significant_bit (significant_bit),
    .tx_enable       (tx_enable),
    .symbol_strobe   (symbol_strobe),
    .frame_done      (frame_done),
    .underrun        (underrun)
  );

  // 10 ns sample clock
  initial sychronizer = 1'b0;
  always #5 sychronizer = ~sychronizer;

  // Rising-edge count used as the time base for every latency check
  always @(posedge sychronizer) cyc++;

  // Falling-edge monitor of everything the sequencer puts on air
  always @(negedge sychronizer) begin
    if (tx_enable && !tx_prev) rise_cyc = cyc;
    tx_prev = tx_enable;
    if (tx_enable) begin
      tx_cnt++;
      bits_q.push_back(significant_bit);
    end
    if (symbol_strobe) strobe_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (underrun) begin
      underrun_cnt++;
      underrun_cyc = cyc;
    end
  end

  // Absolute time limit so a stuck design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish (%0d tests run)", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge sychronizer);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte and wait (bounded) for acceptance.
  // accept_cyc is the cycle in which ready was seen high.
  task automatic apply_stimulus(input logic [7:0] data, input logic last, output int accept_cyc);
    int n;
    byte_in    = data;
    byte_last  = last;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 300) begin
      step();
      n++;
    end
    accept_cyc = cyc;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_tx(output int r);
    int n;
    n = 0;
    while (!tx_enable && n < 100) begin
      step();
      n++;
    end
    r = cyc;
  endtask

  // Rebuild the symbol sequence from the recorded samples.
  // Also confirm that every symbol was held for SPS samples.
  task automatic check_frame(input string tag, input int base, input int nsyms, input logic [31:0] exp_syms);
    logic [31:0] obs;
    logic        hold_ok;
    logic        first;
    obs     = '0;
    hold_ok = 1'b1;
    for (int s = 0; s < nsyms; s++) begin
      if (base + s*SPS + SPS - 1 >= bits_q.size()) begin
        hold_ok = 1'b0;
        first   = 1'bx;
      end else begin
        first = bits_q[base + s*SPS];
        for (int k = 1; k < SPS; k++)
          if (bits_q[base + s*SPS + k] !== first) hold_ok = 1'b0;
      end
      obs = {obs[30:0], first};
    end
    check_output({tag, "_bits"}, obs, exp_syms);
    check_output({tag, "_hold"}, 32'(hold_ok), 32'd1);
  endtask

  initial begin
    int acc;
    int acc2;
    int r;
    int r1;
    int base_done;
    int base_tx;
    int base_str;
    int base_und;
    int base_bits;
    int ready_seen;

    reset_n    = 1'b0;
    byte_valid = 1'b0;
    byte_in    = '0;
    byte_last  = 1'b0;

    // ---- reset state
    repeat (3) step();
    check_output("rst_ready", 32'(byte_ready), 0);
    check_output("rst_bit", 32'(significant_bit), 0);
    check_output("rst_txen", 32'(tx_enable), 0);
    check_output("rst_strobe", 32'(symbol_strobe), 0);
    check_output("rst_done", 32'(frame_done), 0);
    check_output("rst_underrun", 32'(underrun), 0);
    reset_n = 1'b1;
    repeat (2) step();
    check_output("ready_after_rst", 32'(byte_ready), 1);

    // ---- single byte 0xA5, last
    base_done = done_cnt; base_tx = tx_cnt; base_str = strobe_cnt;
    base_und = underrun_cnt; base_bits = bits_q.size();
    apply_stimulus(8'hA5, 1'b1, acc);
    wait_done(base_done);
    check_output("single_done_seen", done_cnt - base_done, 1);
    check_output("single_latency", rise_cyc - acc, 2);
    check_output("single_txlen", tx_cnt - base_tx, 72);
    check_output("single_done_cycle", done_cyc - rise_cyc, 72);
    check_output("single_strobes", strobe_cnt - base_str, 18);
    check_output("single_no_underrun", underrun_cnt - base_und, 0);
    check_frame("single", base_bits, 18, {14'd0, 8'hAA, 8'hA5, 2'b00});
    repeat (3) step();
    check_output("single_one_done", done_cnt - base_done, 1);

    // ---- back-to-back 0x3C, 0xFF(last)
    base_done = done_cnt; base_tx = tx_cnt; base_str = strobe_cnt;
    base_und = underrun_cnt; base_bits = bits_q.size();
    apply_stimulus(8'h3C, 1'b0, acc);
    check_output("b2b_ready_low", 32'(byte_ready), 0);
    apply_stimulus(8'hFF, 1'b1, acc2);
    wait_done(base_done);
    check_output("b2b_accept_in_data", acc2 - rise_cyc, 32);
    check_output("b2b_txlen", tx_cnt - base_tx, 104);
    check_output("b2b_done_cycle", done_cyc - rise_cyc, 104);
    check_output("b2b_strobes", strobe_cnt - base_str, 26);
    check_output("b2b_no_underrun", underrun_cnt - base_und, 0);
    check_frame("b2b", base_bits, 26, {6'd0, 8'hAA, 8'h3C, 8'hFF, 2'b00});

    // ---- underrun: 0x81 not last, nothing follows
    repeat (2) step();
    base_done = done_cnt; base_tx = tx_cnt; base_und = underrun_cnt; base_bits = bits_q.size();
    apply_stimulus(8'h81, 1'b0, acc);
    wait_done(base_done);
    check_output("ur_count", underrun_cnt - base_und, 1);
    check_output("ur_cycle", underrun_cyc - rise_cyc, 64);
    check_output("ur_done_cycle", done_cyc - rise_cyc, 72);
    check_output("ur_txlen", tx_cnt - base_tx, 72);
    check_frame("ur", base_bits, 18, {14'd0, 8'hAA, 8'h81, 2'b00});

    // ---- reset at sample 2 of data bit 3
    repeat (2) step();
    base_done = done_cnt;
    apply_stimulus(8'hC3, 1'b1, acc);
    wait_tx(r);
    repeat (46) step();
    check_output("mid_pre_txen", 32'(tx_enable), 1);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_txen", 32'(tx_enable), 0);
    check_output("mid_rst_bit", 32'(significant_bit), 0);
    check_output("mid_rst_strobe", 32'(symbol_strobe), 0);
    check_output("mid_rst_ready", 32'(byte_ready), 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (10) step();
    check_output("mid_rst_no_done", done_cnt - base_done, 0);
    base_bits = bits_q.size();
    apply_stimulus(8'h5A, 1'b1, acc);
    wait_done(base_done);
    check_output("post_rst_done_cycle", done_cyc - rise_cyc, 72);
    check_frame("post_rst", base_bits, 18, {14'd0, 8'hAA, 8'h5A, 2'b00});

    // ---- byte offered during GUARD starts the next frame right after frame_done
    repeat (2) step();
    base_done = done_cnt; base_bits = bits_q.size();
    apply_stimulus(8'h11, 1'b1, acc);
    wait_tx(r1);
    repeat (65) step();
    apply_stimulus(8'h22, 1'b1, acc2);
    check_output("guard_accept_cycle", acc2 - r1, 65);
    wait_done(base_done);
    check_output("guard_done_cycle", done_cyc - r1, 72);
    step();
    check_output("guard_next_txen", 32'(tx_enable), 1);
    check_output("guard_next_strobe", 32'(symbol_strobe), 1);
    check_output("guard_next_gap", rise_cyc - done_cyc, 1);
    wait_done(base_done + 1);
    check_output("guard_second_done", done_cyc - rise_cyc, 72);
    check_frame("guard_f1", base_bits, 18, {14'd0, 8'hAA, 8'h11, 2'b00});
    check_frame("guard_f2", base_bits + 72, 18, {14'd0, 8'hAA, 8'h22, 2'b00});

    // ---- held valid with ready low: changing byte_in must not leak into the frame
    repeat (2) step();
    base_done = done_cnt; base_tx = tx_cnt; base_bits = bits_q.size();
    apply_stimulus(8'h96, 1'b1, acc);
    byte_valid = 1'b1;
    byte_last  = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready) ready_seen++;
      byte_in = 8'($urandom);
      step();
    end
    byte_valid = 1'b0;
    wait_done(base_done);
    check_output("held_ready_low", ready_seen, 0);
    check_output("held_txlen", tx_cnt - base_tx, 72);
    check_frame("held", base_bits, 18, {14'd0, 8'hAA, 8'h96, 2'b00});
    repeat (5) step();
    check_output("held_one_done", done_cnt - base_done, 1);
    check_output("held_idle_txen", 32'(tx_enable), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
